// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM pipeline stage and its data memory.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int unsigned DEF_ADDR_BASE   = 1024;
  localparam int unsigned DEF_DEPTH_WORDS = 64;
  localparam int unsigned DEF_WAIT_CYCLES = 4;

  // Word-index width; a single-word memory still needs one address bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_stage_dmem_array.sv
// Single-port word RAM: synchronous write, asynchronous read. Contents are never reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int unsigned AW = idx_width(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: word-addressed data memory behind a fixed wait-state access FSM that freezes upstream.
// Define MEM_ZERO_WAIT_EN to remove the FSM and make every access single-cycle.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] Data_Out,
  output logic        ready,
  output logic        freeze,
  output logic        addr_err
);

  localparam int unsigned AW = idx_width(DEPTH_WORDS);

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          req;
  logic          is_store;
  logic          we;
  logic [31:0]   rdata;

  // Byte offset wraps, so addresses below the base are caught by the explicit compare.
  assign off      = ALU_Res - 32'(ADDR_BASE);
  assign in_range = (ALU_Res >= 32'(ADDR_BASE)) && (off[31:2] < 30'(DEPTH_WORDS));
  assign idx      = off[AW+1:2];
  assign req      = MEM_R_EN | MEM_W_EN;
  assign is_store = MEM_W_EN & ~MEM_R_EN;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem (
    .clk_i  (CLK),
    .we_i   (we),
    .addr_i (idx),
    .wdata_i(Val_Rm),
    .rdata_o(rdata)
  );

`ifdef MEM_ZERO_WAIT_EN

  assign we       = is_store & in_range;
  assign Data_Out = in_range ? rdata : 32'd0;
  assign addr_err = req & ~in_range;
  assign ready    = 1'b1;
  assign freeze   = 1'b0;

`else

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d;
  logic        aerr_q, aerr_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      aerr_q  <= aerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    aerr_d  = aerr_q;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Inputs are still held by freeze, so the access uses them directly.
          state_d = DONE;
          we      = is_store & in_range;
          if (!in_range) begin
            aerr_d = 1'b1;
          end
          if (MEM_R_EN) begin
            dout_d = in_range ? rdata : 32'd0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        aerr_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready    = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign freeze   = ~ready;
  assign Data_Out = dout_q;
  assign addr_err = aerr_q;

`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with default parameters (base 1024, 64 words, 4 wait cycles).
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [31:0] Data_Out;
  logic        ready;
  logic        freeze;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;
  time t0, t1;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK     (CLK),
    .RST     (RST),
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .ALU_Res (ALU_Res),
    .Val_Rm  (Val_Rm),
    .Data_Out(Data_Out),
    .ready   (ready),
    .freeze  (freeze),
    .addr_err(addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".dout"},   Data_Out, 32'd0);
    chk({tag, ".ready"},  {31'd0, ready}, 32'd1);
    chk({tag, ".freeze"}, {31'd0, freeze}, 32'd0);
    chk({tag, ".err"},    {31'd0, addr_err}, 32'd0);
  endtask

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_dout, input logic exp_err);
    int frz = 0;
    MEM_R_EN = r;
    MEM_W_EN = w;
    ALU_Res  = a;
    Val_Rm   = d;
    @(negedge CLK);
    while (freeze === 1'b1 && frz < 20) begin
      frz++;
      @(negedge CLK);
    end
    chk({tag, ".frz"},   32'(frz), 32'd5);
    chk({tag, ".ready"}, {31'd0, ready}, 32'd1);
    chk({tag, ".dout"},  Data_Out, exp_dout);
    chk({tag, ".err"},   {31'd0, addr_err}, {31'd0, exp_err});
    $display("txn %-10s r=%0b w=%0b addr=%0d wdata=0x%08h frozen=%0d dout=0x%08h err=%0b",
             tag, r, w, a, d, frz, Data_Out, addr_err);
    @(posedge CLK);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    RST      = 1'b0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res  = 32'd0;
    Val_Rm   = 32'd0;
    #2;
    chk_reset_outputs("init_rst");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    @(negedge CLK);
    chk("idle.ready",  {31'd0, ready}, 32'd1);
    chk("idle.freeze", {31'd0, freeze}, 32'd0);
    $display("txn idle       no request, ready=%0b freeze=%0b", ready, freeze);
    @(posedge CLK);
    #1;

    access("st1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd0, 1'b0);
    access("ld1028", 1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0);

    t0 = $time;
    access("st1024", 1'b0, 1'b1, 32'd1024, 32'h11, 32'hDEADBEEF, 1'b0);
    access("st1032", 1'b0, 1'b1, 32'd1032, 32'h22, 32'hDEADBEEF, 1'b0);
    t1 = $time;
    chk("b2b.time", 32'(t1 - t0), 32'd120);
    access("ld1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h11, 1'b0);
    access("ld1032", 1'b1, 1'b0, 32'd1032, 32'd0, 32'h22, 1'b0);

    access("ld1280", 1'b1, 1'b0, 32'd1280, 32'd0, 32'd0, 1'b1);
    access("ld1000", 1'b1, 1'b0, 32'd1000, 32'd0, 32'd0, 1'b1);
    access("ld1024b", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h11, 1'b0);

    access("both1027", 1'b1, 1'b1, 32'd1027, 32'h99, 32'h11, 1'b0);
    access("ld1024c", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h11, 1'b0);
    access("st1030", 1'b0, 1'b1, 32'd1030, 32'h77, 32'h11, 1'b0);
    access("ld1028b", 1'b1, 1'b0, 32'd1028, 32'd0, 32'h77, 1'b0);

    access("st1040", 1'b0, 1'b1, 32'd1040, 32'h44, 32'h77, 1'b0);
    access("ld1040", 1'b1, 1'b0, 32'd1040, 32'd0, 32'h44, 1'b0);

    // Store 0x55 to 1040 and pull reset in the second ACCESS cycle.
    MEM_W_EN = 1'b1;
    ALU_Res  = 32'd1040;
    Val_Rm   = 32'h55;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    MEM_W_EN = 1'b0;
    #1;
    chk_reset_outputs("abort_rst");
    $display("txn abort      store 1040 aborted by reset, dout=0x%08h ready=%0b", Data_Out, ready);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("abort.ready",  {31'd0, ready}, 32'd1);
    chk("abort.freeze", {31'd0, freeze}, 32'd0);
    @(posedge CLK);
    #1;
    access("ld1040b", 1'b1, 1'b0, 32'd1040, 32'd0, 32'h44, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
